// File: rtl/load_wb_unit_pkg.sv
// Shared encodings for the load/writeback unit: writeback mux select, load size, FSM state.
package load_wb_unit_pkg;

    typedef enum logic [2:0] {
        WB_ALU    = 3'd0,
        WB_LOAD   = 3'd1,
        WB_IMM    = 3'd2,
        WB_IADDER = 3'd3,
        WB_PC4    = 3'd4
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE     = 2'd0,
        LS_HALF     = 2'd1,
        LS_WORD     = 2'd2,
        LS_WORD_ALT = 2'd3
    } load_size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // A byte load can never be misaligned; halves need an even offset, words offset 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_wb_unit_if.sv
// Data-memory load bus: request/address from the unit, ack/read data from memory.
interface load_wb_unit_if;
    logic        dmem_req_out;
    logic [31:0] dmem_addr_out;
    logic        dmem_ack_in;
    logic [31:0] dmem_rdata_in;

    modport master (output dmem_req_out, dmem_addr_out, input dmem_ack_in, dmem_rdata_in);
    modport slave  (input dmem_req_out, dmem_addr_out, output dmem_ack_in, dmem_rdata_in);
endinterface

// File: rtl/load_wb_unit_align_ext.sv
// Picks the addressed byte/half out of a word-aligned memory word and sign/zero extends it.
module load_align_ext
    import load_wb_unit_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        byte_sel = rdata_in[{offset_in, 3'b000} +: 8];
        half_sel = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        case (size_in)
            LS_BYTE: data_out = {{24{~unsigned_in & byte_sel[7]}}, byte_sel};
            LS_HALF: data_out = {{16{~unsigned_in & half_sel[15]}}, half_sel};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/load_wb_unit.sv
// Writeback stage: drives the register-file write port and runs loads over a req/ack bus with timeout.
// Optional forwarding outputs (fwd_valid_out/fwd_rd_out/fwd_data_out) built when LOAD_WB_FWD_EN is defined.
module load_wb_unit
    import load_wb_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          valid_in,
    input  logic [4:0]    rd_addr_in,
    input  logic          rf_wr_en_in,
    input  logic [2:0]    wb_mux_sel_in,
    input  logic [1:0]    load_size_in,
    input  logic          load_unsigned_in,
    input  logic [31:0]   alu_result_in,
    input  logic [31:0]   iadder_in,
    input  logic [31:0]   pc_plus_4_in,
    input  logic [31:0]   imm_in,
    load_wb_unit_if.master dmem,
    output logic          stall_out,
    output logic          rf_wr_en_out,
    output logic [4:0]    rf_rd_addr_out,
    output logic [31:0]   rf_wr_data_out,
    output logic          misalign_out,
    output logic          bus_err_out
`ifdef LOAD_WB_FWD_EN
    ,
    output logic          fwd_valid_out,
    output logic [4:0]    fwd_rd_out,
    output logic [31:0]   fwd_data_out
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    // Load context captured at issue; upstream may advance on the ack edge.
    logic [4:0]  ld_rd_q;
    logic [1:0]  ld_size_q;
    logic [1:0]  ld_off_q;
    logic        ld_uns_q;
    logic        ld_wr_en_q;

    logic [31:0] mux_data;
    logic [31:0] ext_data;
    logic        is_load;
    logic        timeout_hit;
    logic        start_load;
    logic        drop_misalign;
    logic        direct_wr;
    logic        ack_done;
    logic        timeout_err;
    logic        wr_fire;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    load_align_ext u_align (
        .rdata_in    (dmem.dmem_rdata_in),
        .offset_in   (ld_off_q),
        .size_in     (ld_size_q),
        .unsigned_in (ld_uns_q),
        .data_out    (ext_data)
    );

    always_comb begin
        case (wb_mux_sel_in)
            WB_IMM:    mux_data = imm_in;
            WB_IADDER: mux_data = iadder_in;
            WB_PC4:    mux_data = pc_plus_4_in;
            default:   mux_data = alu_result_in;
        endcase
    end

    assign is_load     = (wb_mux_sel_in == WB_LOAD);
    assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        stall_out     = 1'b0;
        start_load    = 1'b0;
        drop_misalign = 1'b0;
        direct_wr     = 1'b0;
        ack_done      = 1'b0;
        timeout_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (!is_load) begin
                        direct_wr = 1'b1;
                    end else if (is_misaligned(load_size_in, iadder_in[1:0])) begin
                        drop_misalign = 1'b1;
                    end else begin
                        start_load = 1'b1;
                        stall_out  = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_out = !dmem.dmem_ack_in && !timeout_hit;
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem.dmem_ack_in) begin
                    ack_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_fire = (direct_wr && rf_wr_en_in && (rd_addr_in != 5'd0))
               || (ack_done && ld_wr_en_q && (ld_rd_q != 5'd0));
        wr_rd   = ack_done ? ld_rd_q  : rd_addr_in;
        wr_data = ack_done ? ext_data : mux_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q              <= '0;
            ld_rd_q            <= '0;
            ld_size_q          <= '0;
            ld_off_q           <= '0;
            ld_uns_q           <= 1'b0;
            ld_wr_en_q         <= 1'b0;
            dmem.dmem_req_out  <= 1'b0;
            dmem.dmem_addr_out <= '0;
            rf_wr_en_out       <= 1'b0;
            rf_rd_addr_out     <= '0;
            rf_wr_data_out     <= '0;
            misalign_out       <= 1'b0;
            bus_err_out        <= 1'b0;
        end else begin
            rf_wr_en_out <= wr_fire;
            misalign_out <= drop_misalign;
            bus_err_out  <= timeout_err;
            if (wr_fire) begin
                rf_rd_addr_out <= wr_rd;
                rf_wr_data_out <= wr_data;
            end
            if (start_load) begin
                ld_rd_q            <= rd_addr_in;
                ld_size_q          <= load_size_in;
                ld_off_q           <= iadder_in[1:0];
                ld_uns_q           <= load_unsigned_in;
                ld_wr_en_q         <= rf_wr_en_in;
                dmem.dmem_req_out  <= 1'b1;
                dmem.dmem_addr_out <= {iadder_in[31:2], 2'b00};
                cnt_q              <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (ack_done || timeout_err) dmem.dmem_req_out <= 1'b0;
        end
    end

`ifdef LOAD_WB_FWD_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fwd_valid_out <= 1'b0;
            fwd_rd_out    <= '0;
            fwd_data_out  <= '0;
        end else if (wr_fire) begin
            fwd_valid_out <= 1'b1;
            fwd_rd_out    <= wr_rd;
            fwd_data_out  <= wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit with ACK_TIMEOUT=4: ALU/IMM writes, loads, misalign, timeout, reset.
module tb_load_wb_unit;

    logic        clk_in;
    logic        rst_in;
    logic        valid_in;
    logic [4:0]  rd_addr_in;
    logic        rf_wr_en_in;
    logic [2:0]  wb_mux_sel_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] alu_result_in;
    logic [31:0] iadder_in;
    logic [31:0] pc_plus_4_in;
    logic [31:0] imm_in;
    logic        stall_out;
    logic        rf_wr_en_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_wr_data_out;
    logic        misalign_out;
    logic        bus_err_out;

    int n_pass  = 0;
    int n_total = 0;

    load_wb_unit_if dmem_if ();

    load_wb_unit #(.ACK_TIMEOUT(4), .CNT_W(5)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .valid_in         (valid_in),
        .rd_addr_in       (rd_addr_in),
        .rf_wr_en_in      (rf_wr_en_in),
        .wb_mux_sel_in    (wb_mux_sel_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .alu_result_in    (alu_result_in),
        .iadder_in        (iadder_in),
        .pc_plus_4_in     (pc_plus_4_in),
        .imm_in           (imm_in),
        .dmem             (dmem_if),
        .stall_out        (stall_out),
        .rf_wr_en_out     (rf_wr_en_out),
        .rf_rd_addr_out   (rf_rd_addr_out),
        .rf_wr_data_out   (rf_wr_data_out),
        .misalign_out     (misalign_out),
        .bus_err_out      (bus_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr);
        valid_in         = 1'b1;
        rf_wr_en_in      = 1'b1;
        wb_mux_sel_in    = sel;
        rd_addr_in       = rd;
        load_size_in     = size;
        load_unsigned_in = uns;
        iadder_in        = addr;
    endtask

    initial begin
        rst_in = 1'b0;
        valid_in = 1'b0; rd_addr_in = '0; rf_wr_en_in = 1'b0; wb_mux_sel_in = '0;
        load_size_in = '0; load_unsigned_in = 1'b0; alu_result_in = '0; iadder_in = '0;
        pc_plus_4_in = '0; imm_in = '0;
        dmem_if.dmem_ack_in = 1'b0; dmem_if.dmem_rdata_in = '0;

        #12;
        check("rst_wr_en",    32'(rf_wr_en_out), 32'd0);
        check("rst_req",      32'(dmem_if.dmem_req_out), 32'd0);
        check("rst_stall",    32'(stall_out), 32'd0);
        check("rst_data",     rf_wr_data_out, 32'h0);
        check("rst_bus_err",  32'(bus_err_out), 32'd0);
        check("rst_misalign", 32'(misalign_out), 32'd0);
        rst_in = 1'b1;
        tick();

        // ALU write, rd=5
        issue(3'd0, 5'd5, 2'd0, 1'b0, 32'h0);
        alu_result_in = 32'h0000_1234;
        #1 check("alu_stall", 32'(stall_out), 32'd0);
        tick();
        valid_in = 1'b0;
        check("alu_wr_en", 32'(rf_wr_en_out), 32'd1);
        check("alu_rd",    32'(rf_rd_addr_out), 32'd5);
        check("alu_data",  rf_wr_data_out, 32'h0000_1234);
        tick();
        check("alu_pulse", 32'(rf_wr_en_out), 32'd0);

        // PC+4 to rd=0 must not write
        issue(3'd4, 5'd0, 2'd0, 1'b0, 32'h0);
        pc_plus_4_in = 32'h0000_1004;
        tick();
        valid_in = 1'b0;
        check("rd0_wr_en", 32'(rf_wr_en_out), 32'd0);

        // PC+4 to rd=7
        issue(3'd4, 5'd7, 2'd0, 1'b0, 32'h0);
        tick();
        valid_in = 1'b0;
        check("pc4_data", rf_wr_data_out, 32'h0000_1004);
        check("pc4_rd",   32'(rf_rd_addr_out), 32'd7);

        // sel=6 falls back to ALU
        issue(3'd6, 5'd9, 2'd0, 1'b0, 32'h0);
        alu_result_in = 32'h0000_A5A5;
        imm_in        = 32'hDEAD_0000;
        tick();
        valid_in = 1'b0;
        check("sel6_data", rf_wr_data_out, 32'h0000_A5A5);

        // LB signed at 0x1003, ack in the 4th WAIT cycle (coincides with timeout: ack wins)
        issue(3'd1, 5'd10, 2'd0, 1'b0, 32'h0000_1003);
        #1;
        check("lb_issue_stall", 32'(stall_out), 32'd1);
        check("lb_issue_req",   32'(dmem_if.dmem_req_out), 32'd0);
        tick();
        check("lb_req",  32'(dmem_if.dmem_req_out), 32'd1);
        check("lb_addr", dmem_if.dmem_addr_out, 32'h0000_1000);
        check("lb_stall_w0", 32'(stall_out), 32'd1);
        tick();
        check("lb_stall_w1", 32'(stall_out), 32'd1);
        tick();
        check("lb_stall_w2", 32'(stall_out), 32'd1);
        check("lb_no_early_wr", 32'(rf_wr_en_out), 32'd0);
        tick();
        dmem_if.dmem_ack_in   = 1'b1;
        dmem_if.dmem_rdata_in = 32'h80FF_FF7F;
        #1 check("lb_ack_stall", 32'(stall_out), 32'd0);
        tick();
        dmem_if.dmem_ack_in = 1'b0;
        valid_in = 1'b0;
        check("lb_wr_en",   32'(rf_wr_en_out), 32'd1);
        check("lb_rd",      32'(rf_rd_addr_out), 32'd10);
        check("lb_data",    rf_wr_data_out, 32'hFFFF_FF80);
        check("lb_req_drop", 32'(dmem_if.dmem_req_out), 32'd0);
        check("lb_no_err",  32'(bus_err_out), 32'd0);

        // LHU at 0x2002, ack in first WAIT cycle
        issue(3'd1, 5'd11, 2'd1, 1'b1, 32'h0000_2002);
        tick();
        check("lhu_addr", dmem_if.dmem_addr_out, 32'h0000_2000);
        dmem_if.dmem_ack_in   = 1'b1;
        dmem_if.dmem_rdata_in = 32'hBEEF_0001;
        #1 check("lhu_ack_stall", 32'(stall_out), 32'd0);
        tick();
        dmem_if.dmem_ack_in = 1'b0;
        valid_in = 1'b0;
        check("lhu_data", rf_wr_data_out, 32'h0000_BEEF);
        check("lhu_rd",   32'(rf_rd_addr_out), 32'd11);

        // LH signed at offset 0
        issue(3'd1, 5'd12, 2'd1, 1'b0, 32'h0000_2000);
        tick();
        dmem_if.dmem_ack_in   = 1'b1;
        dmem_if.dmem_rdata_in = 32'h1234_8001;
        tick();
        dmem_if.dmem_ack_in = 1'b0;
        valid_in = 1'b0;
        check("lh_data", rf_wr_data_out, 32'hFFFF_8001);

        // Misaligned LW
        issue(3'd1, 5'd13, 2'd2, 1'b0, 32'h0000_3001);
        #1 check("mis_stall", 32'(stall_out), 32'd0);
        tick();
        valid_in = 1'b0;
        check("mis_pulse", 32'(misalign_out), 32'd1);
        check("mis_req",   32'(dmem_if.dmem_req_out), 32'd0);
        check("mis_wr_en", 32'(rf_wr_en_out), 32'd0);
        tick();
        check("mis_pulse_end", 32'(misalign_out), 32'd0);
        check("mis_req_idle",  32'(dmem_if.dmem_req_out), 32'd0);

        // Timeout: no ack for 4 WAIT cycles
        issue(3'd1, 5'd14, 2'd2, 1'b0, 32'h0000_4000);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("to_stall_w%0d", i), 32'(stall_out), 32'd1);
            check($sformatf("to_no_err_w%0d", i), 32'(bus_err_out), 32'd0);
            tick();
        end
        check("to_last_stall", 32'(stall_out), 32'd0);
        tick();
        valid_in = 1'b0;
        check("to_bus_err", 32'(bus_err_out), 32'd1);
        check("to_req",     32'(dmem_if.dmem_req_out), 32'd0);
        check("to_wr_en",   32'(rf_wr_en_out), 32'd0);
        dmem_if.dmem_ack_in   = 1'b1;
        dmem_if.dmem_rdata_in = 32'h5555_5555;
        tick();
        dmem_if.dmem_ack_in = 1'b0;
        check("late_ack_wr_en",  32'(rf_wr_en_out), 32'd0);
        check("late_ack_err",    32'(bus_err_out), 32'd0);
        check("late_ack_data",   rf_wr_data_out, 32'hFFFF_8001);

        // Async reset in the middle of WAIT
        issue(3'd1, 5'd15, 2'd2, 1'b0, 32'h0000_5000);
        tick();
        check("rw_req", 32'(dmem_if.dmem_req_out), 32'd1);
        tick();
        #2;
        rst_in   = 1'b0;
        valid_in = 1'b0;
        #1;
        check("rw_req_drop", 32'(dmem_if.dmem_req_out), 32'd0);
        check("rw_stall",    32'(stall_out), 32'd0);
        dmem_if.dmem_ack_in   = 1'b1;
        dmem_if.dmem_rdata_in = 32'h7777_7777;
        tick();
        check("rw_wr_en", 32'(rf_wr_en_out), 32'd0);
        dmem_if.dmem_ack_in = 1'b0;
        rst_in = 1'b1;
        tick();
        check("rw_idle_wr_en", 32'(rf_wr_en_out), 32'd0);

        // Normal operation after reset
        issue(3'd2, 5'd3, 2'd0, 1'b0, 32'h0);
        imm_in = 32'hCAFE_0000;
        tick();
        valid_in = 1'b0;
        check("post_rst_wr_en", 32'(rf_wr_en_out), 32'd1);
        check("post_rst_data",  rf_wr_data_out, 32'hCAFE_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_wb_unit.md
Name: load_wb_unit

Overview:
- Writeback end of the execute-side pipeline register: consumes rd address, rf write enable, wb_mux_sel, load_size/load_unsigned, ALU result, iadder, pc+4 and imm, and drives the register-file write port.
- Loads are issued to data memory over a req/ack handshake. The pipeline is stalled until the ack arrives or a timeout expires.
- Sits between the stage-2 pipeline register and the integer register file.

Parameters:
- ACK_TIMEOUT, 16, max WAIT cycles before a load is abandoned (>=1)
- CNT_W, 5, timeout counter width (must hold ACK_TIMEOUT)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low (0 = reset)
- valid_in  in  1  stage-2 register holds a live instruction
- rd_addr_in  in  5  destination register
- rf_wr_en_in  in  1  instruction writes rd
- wb_mux_sel_in  in  3  0 ALU, 1 LOAD, 2 IMM, 3 IADDER, 4 PC+4; 5-7 treated as ALU
- load_size_in  in  2  0 byte, 1 half, 2 word, 3 word
- load_unsigned_in  in  1  zero-extend when 1
- alu_result_in  in  32  ALU result
- iadder_in  in  32  address / AUIPC result
- pc_plus_4_in  in  32  link value
- imm_in  in  32  immediate (LUI)
- dmem_ack_in  in  1  memory response valid
- dmem_rdata_in  in  32  memory word (word-aligned)
- dmem_req_out  out  1  load request, held until ack/timeout
- dmem_addr_out  out  32  {iadder[31:2],2'b00}
- stall_out  out  1  upstream must hold stage-2 register
- rf_wr_en_out  out  1  register-file write strobe
- rf_rd_addr_out  out  5  write address
- rf_wr_data_out  out  32  write data
- misalign_out  out  1  one-cycle pulse: misaligned load dropped
- bus_err_out  out  1  one-cycle pulse: load timed out

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Async assert; deassertion is sampled on clk_in.
- States: IDLE and WAIT.
- Non-load in IDLE with valid_in:
  - Next edge: rf_wr_en_out = rf_wr_en_in & (rd != 0); rd and data registered from the mux.
  - Latency 1; stall_out = 0.
- Load in IDLE with valid_in:
  - Misaligned case (half with iadder[0]=1, or word with iadder[1:0]!=0): next edge misalign_out=1 for 1 cycle, no write, stay IDLE, stall_out=0.
  - Aligned case: stall_out=1 combinationally. Next edge: capture rd, size, unsigned, offset, rf_wr_en; dmem_req_out=1; counter=0; go WAIT.
- WAIT:
  - stall_out = !dmem_ack_in & !(counter == ACK_TIMEOUT-1).
  - Counter increments each cycle.
  - On dmem_ack_in: next edge extracts the byte/half selected by offset, sign- or zero-extends it, writes if rf_wr_en & rd != 0, drops req, and returns to IDLE.
  - On timeout without ack: bus_err_out pulses, no write, req drops, return to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- rf_wr_en_out, misalign_out and bus_err_out are single-cycle pulses; rf_wr_data_out holds its last value.
- dmem_ack_in in IDLE is ignored (late ack after timeout or reset).
- Reset mid-WAIT: req drops immediately, no write.
- Upstream contract: inputs are stable while stall_out=1 and advance on the first edge with stall_out=0.

Optional Feature:
- Macro: LOAD_WB_FWD_EN.
- Defined: adds outputs fwd_valid_out (1), fwd_rd_out (5), fwd_data_out (32).
  - Registered copy of the most recent rf write, held until the next write; cleared by reset.
  - fwd_valid_out is 0 when rd = 0.
- Undefined: these ports do not exist and no extra flops are built.

Decomposition:
- Shared package: wb_mux_sel encodings (WB_ALU..WB_PC4), load_size encodings, state enum.
- One sub-module, load_align_ext: combinational byte/half extraction plus sign/zero extension (rdata, offset, size, unsigned -> 32-bit).

Test Plan:
- ALU write: valid, sel=0, rd=5, alu=0x1234 -> next cycle rf_wr_en=1, rd=5, data=0x1234, stall never high.
- rd=0 write: sel=4, rd=0 -> rf_wr_en stays 0.
- LB signed: iadder=0x1003, rdata=0x80FF_FF7F, ack after 3 WAIT cycles -> data=0xFFFF_FF80; stall high exactly through the pre-ack cycles.
- LHU: iadder=0x2002, rdata=0xBEEF_0001 -> data=0x0000_BEEF; dmem_addr=0x2000.
- Misaligned LW: iadder=0x3001 -> misalign_out pulse, no req, no write.
- Timeout: ACK_TIMEOUT=4, no ack -> bus_err_out pulse 4 cycles after entering WAIT; a late ack is ignored; async reset mid-WAIT drops req with no write.
